alu_exec_unit: RTL and testbench

- Multi-cycle execute sequencer that drives the existing ALU and consumes its results.
- Accepts 16-bit instruction words over a valid/ready handshake, reads operands from an internal 16x16 register file, and presents them with the instruction to the ALU.
- Latches the ALU result and flags, then writes the destination register and the processor status register (PSR).
- Sits between instruction fetch and the ALU, and feeds PSR carry back into the ALU carry_in.

---
 rtl/alu_exec_unit.sv | 190 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Multi-cycle execute sequencer sitting between instruction fetch and an
// external combinational ALU. Each accepted instruction walks through
// IDLE -> READ -> EXEC -> WB -> IDLE (one instruction every 4 cycles):
//   READ : operands R[Rdest], R[Rsrc] and the instruction word are registered
//          onto the ALU inputs.
//   EXEC : the ALU settles; its result and flags are latched at the edge.
//   WB   : done pulses; at the edge leaving WB the destination register
//          and/or the PSR are updated according to the opcode class.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   instr, instr_valid  instruction word and its valid qualifier
//   instr_ready         high in IDLE, the only state that accepts work
//   done                one-cycle registered pulse while in WB
//   alu_a, alu_b        registered operands R[instr[11:8]], R[instr[3:0]]
//   alu_opcode          registered full instruction word
//   alu_carry_in        PSR carry bit fed back to the ALU
//   alu_c, alu_flags    ALU result and flags {NEG, ZERO, FLAG, LOW, CARRY}
//   psr                 processor status register, same bit order as flags
//   dbg_addr, dbg_data  combinational register file read port
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int NUM_REGS = 16,
    parameter int WIDTH    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic             done,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [15:0]      alu_opcode,
    output logic             alu_carry_in,
    input  logic [WIDTH-1:0] alu_c,
    input  logic [4:0]       alu_flags,
    output logic [4:0]       psr,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    // Opcode / ext encodings and flag index shared with the ALU.
    localparam logic [3:0] OP_RTYPE   = 4'b0000;
    localparam logic [3:0] OP_ADDI    = 4'b0101;
    localparam logic [3:0] OP_SUBI    = 4'b1001;
    localparam logic [3:0] OP_CMPI    = 4'b1011;
    localparam logic [3:0] OP_SHIFTS  = 4'b1000;
    localparam logic [3:0] EXT_CMP    = 4'b1011;
    localparam int         CARRY_FLAG = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [15:0]      instr_reg;
    logic [WIDTH-1:0] alu_a_reg, alu_b_reg;
    logic [15:0]      alu_opcode_reg;
    logic [WIDTH-1:0] res_reg;
    logic [4:0]       flg_reg;
    logic [4:0]       psr_reg;
    logic             done_reg;
    logic [WIDTH-1:0] rf [NUM_REGS];

    logic             wr_reg;
    logic             wr_psr;
    logic             rf_we;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (instr_valid) state_next = S_READ;
            S_READ: state_next = S_EXEC;
            S_EXEC: state_next = S_WB;
            S_WB:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Write-back class decode, taken from the word latched at acceptance
    // so later changes on instr cannot leak into this instruction.
    // ------------------------------------------------------------------
    always_comb begin
        wr_reg = 1'b0;
        wr_psr = 1'b0;
        case (instr_reg[15:12])
            OP_RTYPE: begin
                wr_psr = 1'b1;
                wr_reg = (instr_reg[7:4] != EXT_CMP);
            end
            OP_ADDI, OP_SUBI, OP_SHIFTS: begin
                wr_psr = 1'b1;
                wr_reg = 1'b1;
            end
            OP_CMPI: wr_psr = 1'b1;
            default: begin
                wr_reg = 1'b0;
                wr_psr = 1'b0;
            end
        endcase
    end

    assign rf_we = (state_reg == S_WB) && wr_reg;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_reg      <= '0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_opcode_reg <= '0;
            res_reg        <= '0;
            flg_reg        <= '0;
            psr_reg        <= '0;
            done_reg       <= 1'b0;
        end else begin
            // done is registered off the EXEC state so it is high for
            // exactly the WB cycle.
            done_reg <= (state_reg == S_EXEC);
            case (state_reg)
                S_IDLE: begin
                    if (instr_valid) instr_reg <= instr;
                end
                S_READ: begin
                    alu_a_reg      <= rf[instr_reg[11:8]];
                    alu_b_reg      <= rf[instr_reg[3:0]];
                    alu_opcode_reg <= instr_reg;
                end
                S_EXEC: begin
                    res_reg <= alu_c;
                    flg_reg <= alu_flags;
                end
                S_WB: begin
                    if (wr_psr) psr_reg <= flg_reg;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file: one register per entry so every entry clears on reset.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rf
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rf[gi] <= '0;
                end else if (rf_we && (instr_reg[11:8] == 4'(gi))) begin
                    rf[gi] <= res_reg;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign instr_ready  = (state_reg == S_IDLE);
    assign done         = done_reg;
    assign alu_a        = alu_a_reg;
    assign alu_b        = alu_b_reg;
    assign alu_opcode   = alu_opcode_reg;
    // psr only changes at the WB exit edge, so this is stable in READ/EXEC.
    assign alu_carry_in = psr_reg[CARRY_FLAG];
    assign psr          = psr_reg;
    assign dbg_data     = rf[dbg_addr];

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Bench for alu_exec_unit. A small behavioural ALU is attached to the ALU
// ports. The expected architectural state (16 registers + PSR) is kept as a
// plain array model that applies each instruction as a whole. Directed
// vectors come from a table of constants; a randomized run is then checked
// against the model; hand sequences cover valid held high and reset mid-op.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        done;
    logic [15:0] alu_a, alu_b, alu_opcode;
    logic        alu_carry_in;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;
    logic [4:0]  psr;
    logic [3:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] model_r [16];
    logic [4:0]  model_psr;

    alu_exec_unit #(.NUM_REGS(16), .WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .done         (done),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_carry_in (alu_carry_in),
        .alu_c        (alu_c),
        .alu_flags    (alu_flags),
        .psr          (psr),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {flags{N,Z,F,L,C}, result}.
    function automatic logic [20:0] alu_fn(input logic [15:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
        logic [15:0] c, rhs;
        logic [4:0]  f;
        logic [16:0] s;
        int          kind;
        c = '0; f = '0; s = '0; kind = 0;
        rhs = {{8{op[7]}}, op[7:0]};
        case (op[15:12])
            4'h0: begin
                rhs = b;
                case (op[7:4])
                    4'h5: kind = 1;
                    4'h9: kind = 2;
                    4'hB: kind = 3;
                    4'h1: kind = 4;
                    4'h2: kind = 5;
                    4'h3: kind = 6;
                    4'hD: kind = 7;
                    default: kind = 0;
                endcase
            end
            4'h5: kind = 1;
            4'h9: kind = 2;
            4'hB: kind = 3;
            4'h8: kind = 8;
            default: kind = 9;
        endcase
        case (kind)
            1: begin
                s = {1'b0, a} + {1'b0, rhs} + 17'(cin);
                c = s[15:0];
                f[0] = s[16];
                f[2] = (a[15] == rhs[15]) && (c[15] != a[15]);
            end
            2: begin
                c = a - rhs;
                f[2] = (a[15] != rhs[15]) && (c[15] != a[15]);
            end
            3: begin
                f[3] = (a == rhs);
                f[1] = (a < rhs);
                f[4] = ($signed(a) < $signed(rhs));
            end
            4: c = a & rhs;
            5: c = a | rhs;
            6: c = a ^ rhs;
            7: c = rhs;
            8: c = a << op[3:0];
            9: begin
                c = a ^ 16'hA5A5;
                f = 5'h1F;
            end
            default: ;
        endcase
        return {f, c};
    endfunction

    always_comb begin
        {alu_flags, alu_c} = alu_fn(alu_opcode, alu_a, alu_b, alu_carry_in);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_r[i] = '0;
        model_psr = '0;
    endtask

    // Architectural effect of one instruction, straight from the opcode rules.
    task automatic model_exec(input logic [15:0] w);
        logic [20:0] r;
        logic [3:0]  op;
        logic        wreg, wpsr;
        op   = w[15:12];
        r    = alu_fn(w, model_r[w[11:8]], model_r[w[3:0]], model_psr[0]);
        wreg = (op == 4'h0 && w[7:4] != 4'hB) || op == 4'h5 || op == 4'h9 || op == 4'h8;
        wpsr = wreg || op == 4'h0 || op == 4'hB;
        if (wreg) model_r[w[11:8]] = r[15:0];
        if (wpsr) model_psr = r[20:16];
    endtask

    // Issue one instruction from IDLE and follow it to retirement; ends on
    // the negedge after the WB exit edge, with the unit back in IDLE.
    task automatic issue(input logic [15:0] w, input string tag);
        logic [3:0]  dpat, rpat;
        logic [15:0] ea, eb, sa, sb, sop;
        logic        ecin, scin;
        ea = model_r[w[11:8]]; eb = model_r[w[3:0]]; ecin = model_psr[0];
        sa = '0; sb = '0; sop = '0; scin = 1'b0;
        @(negedge clk);
        check({tag, "/ready_idle"}, 32'(instr_ready), 32'd1);
        instr = w;
        instr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                instr_valid = 1'b0;
                instr = 16'($urandom);
            end
            dpat[k] = done;
            rpat[k] = instr_ready;
            if (k == 1) begin
                sa = alu_a; sb = alu_b; sop = alu_opcode; scin = alu_carry_in;
            end
        end
        check({tag, "/done_timing"}, 32'(dpat), 32'b0100);
        check({tag, "/ready_timing"}, 32'(rpat), 32'b1000);
        check({tag, "/alu_a"}, 32'(sa), 32'(ea));
        check({tag, "/alu_b"}, 32'(sb), 32'(eb));
        check({tag, "/alu_opcode"}, 32'(sop), 32'(w));
        check({tag, "/carry_in"}, 32'(scin), 32'(ecin));
        model_exec(w);
    endtask

    task automatic check_rd(input logic [3:0] rd, input logic [15:0] exp, input string tag);
        dbg_addr = rd;
        #1;
        check({tag, "/reg"}, 32'(dbg_data), 32'(exp));
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            check({tag, "/sweep"}, {12'(i), 4'h0, dbg_data}, {12'(i), 4'h0, model_r[i]});
        end
    endtask

    typedef struct {
        logic [15:0] w;
        logic [15:0] exp_val;
        logic [4:0]  exp_psr;
    } vec_t;

    vec_t tbl [14];

    logic [3:0] rsv_ops [11];
    logic [3:0] ext_sel [8];

    initial begin
        int acc, dn;
        logic [15:0] w;

        tbl[0]  = '{16'h510A, 16'd10,   5'b00000}; // ADDI R1,#10
        tbl[1]  = '{16'h520A, 16'd10,   5'b00000}; // ADDI R2,#10
        tbl[2]  = '{16'h0152, 16'd20,   5'b00000}; // ADD  R1,R2
        tbl[3]  = '{16'h9113, 16'd1,    5'b00000}; // SUBI R1,#19
        tbl[4]  = '{16'h03B1, 16'd0,    5'b10010}; // CMP  R3,R1
        tbl[5]  = '{16'h01B1, 16'd1,    5'b01000}; // CMP  R1,R1
        tbl[6]  = '{16'h00B0, 16'd0,    5'b01000}; // CMP  R0,R0
        tbl[7]  = '{16'h9401, 16'hFFFF, 5'b00000}; // SUBI R4,#1
        tbl[8]  = '{16'h5501, 16'd1,    5'b00000}; // ADDI R5,#1
        tbl[9]  = '{16'h0455, 16'd0,    5'b00001}; // ADD  R4,R5 (carry out)
        tbl[10] = '{16'h5601, 16'd2,    5'b00000}; // ADDI R6,#1 with carry in
        tbl[11] = '{16'hF7FF, 16'd0,    5'b00000}; // reserved opcode: NOP
        tbl[12] = '{16'hB101, 16'd1,    5'b01000}; // CMPI R1,#1
        tbl[13] = '{16'h8203, 16'h0050, 5'b00000}; // SHIFTS R2,<<3

        rsv_ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'hA, 4'hC, 4'hD, 4'hE, 4'hF};
        ext_sel = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF};

        model_clear();

        // Asynchronous reset asserted between clock edges.
        #3 reset = 1'b1;
        #1;
        check("reset/ready", 32'(instr_ready), 32'd1);
        check("reset/done", 32'(done), 32'd0);
        check("reset/psr", 32'(psr), 32'd0);
        sweep("reset");
        @(negedge clk);
        reset = 1'b0;

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            issue(tbl[i].w, $sformatf("tbl%0d", i));
            check_rd(tbl[i].w[11:8], tbl[i].exp_val, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d/psr", i), 32'(psr), 32'(tbl[i].exp_psr));
            $display("tbl%0d instr=%h R%0d=%h psr=%b", i, tbl[i].w, tbl[i].w[11:8], dbg_data, psr);
        end
        sweep("after_tbl");

        // instr_valid held 8 cycles: accepts at edges 0 and 4 only; the word
        // is scrambled while busy.
        w = 16'h5803;
        @(negedge clk);
        acc = 0; dn = 0;
        for (int c = 0; c < 8; c++) begin
            instr = (c >= 1 && c <= 3) ? 16'($urandom) : w;
            instr_valid = 1'b1;
            if (instr_ready) acc++;
            @(negedge clk);
            if (done) dn++;
        end
        instr_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        model_exec(w);
        model_exec(w);
        check("hold/accepts", 32'(acc), 32'd2);
        check("hold/dones", 32'(dn), 32'd2);
        check_rd(4'd8, 16'd6, "hold");
        $display("hold instr=%h accepts=%0d dones=%0d R8=%h", w, acc, dn, dbg_data);

        // Reset during EXEC of ADDI R7,#5: nothing retires.
        @(negedge clk);
        instr = 16'h5705;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset/ready", 32'(instr_ready), 32'd1);
        check("midreset/done", 32'(done), 32'd0);
        check("midreset/psr", 32'(psr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        dn = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("midreset/no_done", 32'(dn), 32'd0);
        check("midreset/ready_after", 32'(instr_ready), 32'd1);
        check_rd(4'd7, 16'd0, "midreset");
        $display("midreset instr=5705 dones=%0d R7=%h", dn, dbg_data);
        sweep("midreset");

        // Randomized instructions against the model.
        for (int i = 0; i < 60; i++) begin
            w = 16'($urandom);
            case ($urandom_range(0, 5))
                0: begin w[15:12] = 4'h0; w[7:4] = ext_sel[$urandom_range(0, 7)]; end
                1: w[15:12] = 4'h5;
                2: w[15:12] = 4'h9;
                3: w[15:12] = 4'hB;
                4: w[15:12] = 4'h8;
                default: w[15:12] = rsv_ops[$urandom_range(0, 10)];
            endcase
            issue(w, $sformatf("rnd%0d", i));
            check_rd(w[11:8], model_r[w[11:8]], $sformatf("rnd%0d", i));
            check($sformatf("rnd%0d/psr", i), 32'(psr), 32'(model_psr));
            $display("rnd%0d instr=%h R%0d=%h psr=%b", i, w, w[11:8], dbg_data, psr);
        end
        sweep("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
